// File: rtl/serial_addsub_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : serial_addsub_pkg                                        |
// | Description : Shared types and constants for the bit-serial            |
// |               adder/subtractor: FSM state encoding and mode codes.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package serial_addsub_pkg;

    // Controller states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operation select values carried on the mode input
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : serial_addsub_pkg
`default_nettype wire

// File: rtl/serial_addsub_addsub_bit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : addsub_bit                                               |
// | Description : One-bit full adder / full subtractor cell.               |
// |               Add      : s = x ^ y ^ cin, cout = carry                 |
// |               Subtract : s = x ^ y ^ cin, cout = borrow (cin = borrow) |
// | Ports       : x, y  - operand bits                                     |
// |               cin   - incoming carry (add) or borrow (subtract)        |
// |               mode  - MODE_ADD / MODE_SUB                              |
// |               s     - sum / difference bit                             |
// |               cout  - outgoing carry / borrow                          |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module addsub_bit
    import serial_addsub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    input  logic mode,
    output logic s,
    output logic cout
);

    logic w_carry;
    logic w_borrow;

    // Sum and difference bits are the same three-input XOR
    assign s        = x ^ y ^ cin;
    assign w_carry  = (x & y) | (cin & (x ^ y));
    // Borrow out when x < y + bin at this position
    assign w_borrow = (~x & y) | (~(x ^ y) & cin);
    assign cout     = (mode == MODE_SUB) ? w_borrow : w_carry;

endmodule : addsub_bit
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : serial_addsub                                            |
// | Description : Bit-serial two's-complement adder/subtractor. Operands   |
// |               are latched on start, processed LSB first one bit per    |
// |               clock, and the registered result is presented with a     |
// |               one-cycle done pulse.                                    |
// | Parameters  : WIDTH - operand/result width, 2..32 (default 8)          |
// | Ports       : clk    - rising-edge clock                               |
// |               rst_n  - synchronous active-low reset                     |
// |               start  - request, sampled in IDLE or DONE                |
// |               mode   - 0 add, 1 subtract (sampled with start)          |
// |               a, b   - operands (sampled with start)                   |
// |               busy   - operation in progress                           |
// |               done   - one-cycle completion pulse                      |
// |               result - sum / difference mod 2^WIDTH                    |
// |               cout   - carry-out (add) / borrow-out (subtract)         |
// |               ovf    - signed overflow                                 |
// |               zero   - result == 0 (only with SERIAL_ADDSUB_ZERO_FLAG_EN)|
// | Options     : SERIAL_ADDSUB_ZERO_FLAG_EN adds the zero output          |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             ovf
);

    localparam int               c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_mode;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_ovf;

    logic w_x;
    logic w_y;
    logic w_s;
    logic w_c;
    logic w_last;
    logic w_ovf;

    assign w_x    = r_a[r_cnt];
    assign w_y    = r_b[r_cnt];
    assign w_last = (r_cnt == c_last);

    addsub_bit u_bit (
        .x    (w_x),
        .y    (w_y),
        .cin  (r_carry),
        .mode (r_mode),
        .s    (w_s),
        .cout (w_c)
    );

    // Evaluated on the MSB step, where w_x/w_y are the operand sign bits and
    // w_s is the result sign bit.
    assign w_ovf = (r_mode == MODE_ADD) ? ((w_x == w_y) && (w_s != w_x))
                                        : ((w_x != w_y) && (w_s != w_x));

    // Controller and datapath. Outputs are registered from the current state,
    // so busy/done/result appear one edge after the internal state change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
            zero    <= 1'b0;
`endif
        end else begin
            busy <= (r_state == RUN);
            done <= (r_state == DONE);

            // Publish the finished operation; held until the next DONE
            if (r_state == DONE) begin
                result <= r_sum;
                cout   <= r_carry;
                ovf    <= r_ovf;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
                zero   <= (r_sum == '0);
`endif
            end

            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_mode  <= mode;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    // LSB-first: new bit enters at the top and shifts down,
                    // so after WIDTH steps bit 0 sits at r_sum[0].
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_ovf   <= w_ovf;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : serial_addsub
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_serial_addsub                                         |
// | Description : Self-checking bench for serial_addsub: table of 8-bit    |
// |               vectors, exhaustive 2-bit sweep, and hand-written        |
// |               sequences for mid-run start, mid-run reset and           |
// |               back-to-back operation.                                  |
// | Options     : SERIAL_ADDSUB_ZERO_FLAG_EN enables zero-flag checks      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8, mode8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] result8;

    logic       start2, mode2;
    logic [1:0] a2, b2;
    logic       busy2, done2, cout2, ovf2;
    logic [1:0] result2;

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic       zero8, zero2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .mode   (mode8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .result (result8),
        .cout   (cout8),
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        .zero   (zero8),
`endif
        .ovf    (ovf8)
    );

    serial_addsub #(.WIDTH(2)) u_dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start2),
        .mode   (mode2),
        .a      (a2),
        .b      (b2),
        .busy   (busy2),
        .done   (done2),
        .result (result2),
        .cout   (cout2),
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        .zero   (zero2),
`endif
        .ovf    (ovf2)
    );

    typedef struct {
        string      name;
        logic       mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One 8-bit operation with cycle-accurate busy/done checking. If inject
    // is in 1..8, a conflicting start is pulsed during RUN.
    task automatic run8(input string name, input logic m, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input logic ec, input logic eo, input int inject);
        int t_err;
        t_err = 0;
        @(negedge clk);
        mode8 = m; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k == inject) begin
                start8 = 1'b1; a8 = ~x; b8 = 8'h5A; mode8 = ~m;
            end
            @(posedge clk); #1;
            if (k == inject) start8 = 1'b0;
            if (done8 !== (k == 9)) t_err++;
            if (busy8 !== (k <= 8)) t_err++;
        end
        check({name, " timing"}, t_err, 0);
        check({name, " result"}, {24'h0, result8}, {24'h0, er});
        check({name, " cout/ovf"}, {30'h0, cout8, ovf8}, {30'h0, ec, eo});
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        check({name, " zero"}, {31'h0, zero8}, {31'h0, (er == 8'h00)});
`endif
    endtask

    task automatic run2(input logic m, input logic [1:0] x, input logic [1:0] y);
        logic [2:0] t;
        logic [1:0] er;
        logic       ec, eo;
        int         waited;
        if (m == 1'b0) begin
            t  = 3'(x) + 3'(y);
            er = t[1:0];
            ec = t[2];
            eo = (x[1] == y[1]) && (er[1] != x[1]);
        end else begin
            t  = 3'(x) - 3'(y);
            er = t[1:0];
            ec = (x < y);
            eo = (x[1] != y[1]) && (er[1] != x[1]);
        end
        @(negedge clk);
        mode2 = m; a2 = x; b2 = y; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        waited = 0;
        while (done2 !== 1'b1 && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        check($sformatf("w2 m%0d %0d,%0d latency", m, x, y), waited, 3);
        check($sformatf("w2 m%0d %0d,%0d out", m, x, y),
              {28'h0, result2, cout2, ovf2}, {28'h0, er, ec, eo});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"sub 05-03", 1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{"sub 03-05", 1'b1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{"sub 80-01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{"add FF+01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{"add 7F+01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{"add 12+34", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
        vecs[6] = '{"sub 00-00", 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{"add 80+80", 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[8] = '{"sub 7F-FF", 1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

        rst_n = 1'b0;
        start8 = 1'b0; mode8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
        start2 = 1'b0; mode2 = 1'b0; a2 = 2'd0;  b2 = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {19'h0, busy8, done8, result8, cout8, ovf8}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run8(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].b,
                 vecs[i].res, vecs[i].cout, vecs[i].ovf, 0);

        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 4; y++)
                    run2(m[0], x[1:0], y[1:0]);

        // Start pulsed mid-RUN with different operands is ignored
        run8("inject add 12+34", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 3);

        // Reset mid-RUN: outputs clear, no done pulse follows
        begin
            int spurious;
            @(negedge clk);
            mode8 = 1'b1; a8 = 8'h90; b8 = 8'h11; start8 = 1'b1;
            @(posedge clk); #1;
            start8 = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b0;
            @(posedge clk); #1;
            check("midrun reset outputs", {19'h0, busy8, done8, result8, cout8, ovf8}, 32'h0);
            rst_n = 1'b1;
            spurious = 0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk); #1;
                if (done8 !== 1'b0 || busy8 !== 1'b0) spurious++;
            end
            check("no done after reset", spurious, 0);
        end
        run8("post-reset sub 05-03", 1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0);

        // Back-to-back: start held high through DONE
        @(negedge clk);
        mode8 = 1'b0; a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'h10; b8 = 8'h20;
        repeat (8) @(posedge clk);
        #1;
        @(posedge clk); #1;
        check("b2b first done/busy", {30'h0, done8, busy8}, 32'h2);
        check("b2b first result", {24'h0, result8}, 32'h03);
        @(posedge clk); #1;
        check("b2b second busy", {30'h0, done8, busy8}, 32'h1);
        start8 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("b2b second not yet done", {31'h0, done8}, 32'h0);
        @(posedge clk); #1;
        check("b2b second done", {31'h0, done8}, 32'h1);
        check("b2b second result", {24'h0, result8}, 32'h30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_addsub
`default_nettype wire
